// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the parametrised register file.
package reg_file_pkg;

  // Controller state: SWEEP clears the array one entry per cycle; RUN is normal operation.
  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  // Default geometry matches the original 16x8 core register file.
  localparam int RF_DEF_DW = 8;
  localparam int RF_DEF_PW = 4;

  // Number of entries addressed by a pointer of the given width.
  function automatic int rf_depth(input int pw);
    return 1 << pw;
  endfunction

endpackage

// File: rtl/reg_file_sweep_ctl.sv
// Clear-sweep controller: owns the SWEEP/RUN state, the sweep pointer and the
// clear-write strobe that the top multiplexes onto the array write port.
module reg_file_sweep_ctl
  import reg_file_pkg::*;
#(
  parameter int PW = RF_DEF_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          ready,
  output logic          clr_we,
  output logic [PW-1:0] clr_addr
);

  rf_state_t     state_p1;
  logic [PW-1:0] ptr_p1;
  logic          ptr_last;

  // The pointer is PW bits wide, so the last entry is the all-ones value.
  assign ptr_last = (ptr_p1 == {PW{1'b1}});

  // State and sweep pointer: reset and clear requests both restart the sweep at entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= SWEEP;
      ptr_p1   <= '0;
    end else begin
      case (state_p1)
        SWEEP: begin
          ptr_p1 <= ptr_p1 + 1'b1;
          if (ptr_last) begin
            state_p1 <= RUN;
          end
        end
        RUN: begin
          if (clr_req) begin
            state_p1 <= SWEEP;
            ptr_p1   <= '0;
          end
        end
        default: begin
          state_p1 <= SWEEP;
          ptr_p1   <= '0;
        end
      endcase
    end
  end

  // Clear strobe is suppressed while reset is asserted so reset alone never touches the array.
  always_comb begin
    ready    = (state_p1 == RUN);
    clr_we   = rst_n && (state_p1 == SWEEP);
    clr_addr = ptr_p1;
  end

endmodule

// File: rtl/reg_file_v2.sv
// Parametrised register file: two combinational read ports, one clocked write
// port, optional write-to-read bypass, optional hardwired-zero entry 0 and a
// sequential clear sweep after reset or on request.
module reg_file_v2
  import reg_file_pkg::*;
#(
  parameter int DW      = RF_DEF_DW,
  parameter int PW      = RF_DEF_PW,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [DW-1:0] dat_in,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          ready,
  output logic          wr_drop
);

  localparam int DEPTH = rf_depth(PW);

  logic [DW-1:0] core [DEPTH];

  logic          clr_we;
  logic [PW-1:0] clr_addr;
  logic          r0_wr_p0;
  logic          wr_ok_p0;
  logic          drop_p0;
  logic          drop_p1;
  logic [DW-1:0] stored_a;
  logic [DW-1:0] stored_b;

  reg_file_sweep_ctl #(
    .PW(PW)
  ) u_sweep_ctl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Read-port output selection: blank while not ready, zero r0 if hardwired,
  // otherwise forward the in-flight write when bypass is enabled and addresses match.
  function automatic logic [DW-1:0] read_sel(
    input logic          rdy,
    input logic [PW-1:0] addr,
    input logic [DW-1:0] stored,
    input logic          wr_fwd,
    input logic [PW-1:0] waddr,
    input logic [DW-1:0] wdata
  );
    logic [DW-1:0] res;
    res = stored;
    if (!rdy) begin
      res = '0;
    end else if ((ZERO_R0 != 0) && (addr == '0)) begin
      res = '0;
    end else if ((BYPASS != 0) && wr_fwd && (waddr == addr)) begin
      res = wdata;
    end
    return res;
  endfunction

  // Write qualification: a write lands only in RUN, without a concurrent clear
  // request, and never into a hardwired-zero r0; any other requested write is dropped.
  always_comb begin
    r0_wr_p0 = (ZERO_R0 != 0) && (wr_addr == '0);
    wr_ok_p0 = rst_n && ready && wr_en && !clr_req && !r0_wr_p0;
    drop_p0  = wr_en && !wr_ok_p0;
  end

  // ---- stage boundary: write-port decision -> registered array / drop flag ----

  // Array write port: the sweep's clear write has priority over normal writes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      core[clr_addr] <= '0;
    end else if (wr_ok_p0) begin
      core[wr_addr] <= dat_in;
    end
  end

  // One-cycle drop pulse reporting the previous cycle's rejected write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_p1 <= 1'b0;
    end else begin
      drop_p1 <= drop_p0;
    end
  end

  assign wr_drop = drop_p1;

  // Combinational read ports A and B.
  always_comb begin
    stored_a = core[rd_addrA];
    stored_b = core[rd_addrB];
    datA_out = read_sel(ready, rd_addrA, stored_a, wr_ok_p0, wr_addr, dat_in);
    datB_out = read_sel(ready, rd_addrB, stored_b, wr_ok_p0, wr_addr, dat_in);
  end

endmodule

// File: tb/tb_reg_file_v2.sv
// Self-checking bench: three builds (bypass, no bypass, bypass+zero-r0) share
// one stimulus stream and are checked against a behavioural model every cycle.
module tb_reg_file_v2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_req;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] dat_in;
  logic [3:0] rd_addrA;
  logic [3:0] rd_addrB;

  logic [7:0] datA [3];
  logic [7:0] datB [3];
  logic       rdy  [3];
  logic       drop [3];

  int nvec = 0;
  int nmis = 0;
  bit chk_en = 1'b0;

  // Configuration per instance: {bypass, zero_r0}.
  bit cfg_byp [3] = '{1'b1, 1'b0, 1'b1};
  bit cfg_zr  [3] = '{1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  reg_file_v2 #(.DW(8), .PW(4), .BYPASS(1), .ZERO_R0(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .dat_in(dat_in), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(datA[0]), .datB_out(datB[0]), .ready(rdy[0]), .wr_drop(drop[0]));

  reg_file_v2 #(.DW(8), .PW(4), .BYPASS(0), .ZERO_R0(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .dat_in(dat_in), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(datA[1]), .datB_out(datB[1]), .ready(rdy[1]), .wr_drop(drop[1]));

  reg_file_v2 #(.DW(8), .PW(4), .BYPASS(1), .ZERO_R0(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .dat_in(dat_in), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(datA[2]), .datB_out(datB[2]), .ready(rdy[2]), .wr_drop(drop[2]));

  // Behavioural model: cycles of clearing still to go, array contents per build,
  // and the pending drop flag per build.
  int         sweep_left = 16;
  logic [7:0] mem    [3][16];
  logic       drop_q [3];

  initial begin
    for (int c = 0; c < 3; c++) begin
      drop_q[c] = 1'b0;
      for (int a = 0; a < 16; a++) mem[c][a] = 8'h00;
    end
  end

  always @(posedge clk) begin
    bit busy;
    busy = (sweep_left != 0);
    for (int c = 0; c < 3; c++) begin
      if (!rst_n) drop_q[c] = 1'b0;
      else drop_q[c] = wr_en && (busy || clr_req || (cfg_zr[c] && wr_addr == 4'd0));
    end
    if (!rst_n) begin
      sweep_left = 16;
    end else if (busy) begin
      for (int c = 0; c < 3; c++) mem[c][16 - sweep_left] = 8'h00;
      sweep_left = sweep_left - 1;
    end else if (clr_req) begin
      sweep_left = 16;
    end else if (wr_en) begin
      for (int c = 0; c < 3; c++)
        if (!(cfg_zr[c] && wr_addr == 4'd0)) mem[c][wr_addr] = dat_in;
    end
  end

  function automatic logic [7:0] exp_rd(input int c, input logic [3:0] a);
    if (sweep_left != 0) return 8'h00;
    if (cfg_zr[c] && a == 4'd0) return 8'h00;
    if (cfg_byp[c] && wr_en && !clr_req && wr_addr == a) return dat_in;
    return mem[c][a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all builds against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("m_ready%0d", c), {31'd0, rdy[c]}, {31'd0, (sweep_left == 0)});
        chk($sformatf("m_datA%0d", c), {24'd0, datA[c]}, {24'd0, exp_rd(c, rd_addrA)});
        chk($sformatf("m_datB%0d", c), {24'd0, datB[c]}, {24'd0, exp_rd(c, rd_addrB)});
        chk($sformatf("m_drop%0d", c), {31'd0, drop[c]}, {31'd0, drop_q[c]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects exactly 16 not-ready cycles followed by ready; clr_req is released at the end.
  task automatic expect_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, {31'd0, rdy[0]}, 32'd0);
      step();
    end
    clr_req = 1'b0;
    @(negedge clk);
    chk({tag, "_up"}, {31'd0, rdy[0]}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; clr_req = 1'b0; wr_en = 1'b0;
    wr_addr = '0; dat_in = '0; rd_addrA = '0; rd_addrB = '0;
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Reset sweep timing and all-zero contents.
    expect_sweep("rst");
    for (int a = 0; a < 16; a++) begin
      step();
      rd_addrA = 4'(a);
      @(negedge clk);
      chk("rst_zero", {24'd0, datA[0]}, 32'h00);
    end

    // Plain write then read.
    step();
    wr_en = 1'b1; wr_addr = 4'd3; dat_in = 8'hA5; rd_addrA = 4'd0; rd_addrB = 4'd4;
    step();
    wr_en = 1'b0; rd_addrA = 4'd3;
    @(negedge clk);
    chk("wr_r3", {24'd0, datA[0]}, 32'hA5);
    chk("rd_r4", {24'd0, datB[0]}, 32'h00);

    // Bypass versus no bypass.
    step();
    wr_en = 1'b1; wr_addr = 4'd7; dat_in = 8'h3C; rd_addrA = 4'd7;
    @(negedge clk);
    chk("byp_on", {24'd0, datA[0]}, 32'h3C);
    chk("byp_off", {24'd0, datA[1]}, 32'h00);
    step();
    wr_en = 1'b0;
    @(negedge clk);
    chk("byp_off_next", {24'd0, datA[1]}, 32'h3C);

    // Hardwired-zero r0.
    step();
    wr_en = 1'b1; wr_addr = 4'd0; dat_in = 8'h11; rd_addrA = 4'd0;
    step();
    wr_en = 1'b0;
    chk("zr_drop", {31'd0, drop[2]}, 32'd1);
    chk("r0_nodrop", {31'd0, drop[0]}, 32'd0);
    @(negedge clk);
    chk("zr_r0", {24'd0, datA[2]}, 32'h00);
    chk("r0_plain", {24'd0, datA[0]}, 32'h11);
    step();
    wr_en = 1'b1; wr_addr = 4'd1; dat_in = 8'h22;
    step();
    wr_en = 1'b0; rd_addrA = 4'd1;
    @(negedge clk);
    chk("zr_r1", {24'd0, datA[2]}, 32'h22);

    // Clear request with a colliding write, clr_req held through the sweep.
    step();
    wr_en = 1'b1; wr_addr = 4'd5; dat_in = 8'hFF; clr_req = 1'b1; rd_addrA = 4'd5;
    step();
    wr_en = 1'b0;
    chk("clr_drop", {31'd0, drop[0]}, 32'd1);
    expect_sweep("clr");
    chk("clr_r5", {24'd0, datA[0]}, 32'h00);

    // Reset in the middle of a sweep (pointer at 9).
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    expect_sweep("mid_rst");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n    = ($urandom_range(0, 199) != 0);
      clr_req  = ($urandom_range(0, 39) == 0);
      wr_en    = $urandom_range(0, 1) == 1;
      wr_addr  = 4'($urandom_range(0, 15));
      dat_in   = 8'($urandom_range(0, 255));
      rd_addrA = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      rd_addrB = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
    end
    step();
    rst_n = 1'b1; clr_req = 1'b0; wr_en = 1'b0;
    step();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
